// File: rtl/ps2_event_queue.sv
// PS/2 Set-2 scan-code parser feeding a key-event FIFO.
// Tracks prefixes, modifiers, caps lock and repeat suppression.
module ps2_event_queue #(
    parameter int DEPTH           = 8,
    parameter int EMIT_BREAKS     = 0,
    parameter int SUPPRESS_REPEAT = 1
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      byte_valid,
    input  logic [7:0]                byte_data,
    input  logic                      evt_ready,
    input  logic                      clr_overflow,
    output logic                      evt_valid,
    output logic [7:0]                evt_code,
    output logic [6:0]                evt_ascii,
    output logic [4:0]                evt_flags,
    output logic [$clog2(DEPTH):0]    evt_count,
    output logic                      overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_EXT, S_BRK, S_EXTBRK, S_SKIP
    } state_t;

    state_t      st_q, st_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        done, d_brk, d_ext;

    logic        lsh_q, rsh_q, lct_q, rct_q;
    logic        caps_q, held_q;
    logic [8:0]  last_q;

    logic        ev_vld_q;
    logic [7:0]  ev_code_q;
    logic [6:0]  ev_ascii_q;
    logic [4:0]  ev_flags_q;

    logic [19:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_fifo_q;
    logic          ovf_q;

    // Set-2 code to ASCII; letters follow shift^caps, others follow shift
    function automatic logic [6:0] to_ascii(
        input logic       ext,
        input logic [7:0] c,
        input logic       sh,
        input logic       cp
    );
        logic [6:0] lo;
        logic [6:0] hi;
        logic       alpha;
        lo = 7'h01;
        hi = 7'h01;
        if (ext) begin
            case (c)
                8'h75:   lo = 7'h02;
                8'h6B:   lo = 7'h03;
                8'h72:   lo = 7'h04;
                8'h74:   lo = 7'h05;
                default: lo = 7'h01;
            endcase
            hi = lo;
        end else begin
            case (c)
                8'h1C: lo = 7'h61;
                8'h32: lo = 7'h62;
                8'h21: lo = 7'h63;
                8'h23: lo = 7'h64;
                8'h24: lo = 7'h65;
                8'h2B: lo = 7'h66;
                8'h34: lo = 7'h67;
                8'h33: lo = 7'h68;
                8'h43: lo = 7'h69;
                8'h3B: lo = 7'h6A;
                8'h42: lo = 7'h6B;
                8'h4B: lo = 7'h6C;
                8'h3A: lo = 7'h6D;
                8'h31: lo = 7'h6E;
                8'h44: lo = 7'h6F;
                8'h4D: lo = 7'h70;
                8'h15: lo = 7'h71;
                8'h2D: lo = 7'h72;
                8'h1B: lo = 7'h73;
                8'h2C: lo = 7'h74;
                8'h3C: lo = 7'h75;
                8'h2A: lo = 7'h76;
                8'h1D: lo = 7'h77;
                8'h22: lo = 7'h78;
                8'h35: lo = 7'h79;
                8'h1A: lo = 7'h7A;
                8'h45: {lo, hi} = {7'h30, 7'h29};
                8'h16: {lo, hi} = {7'h31, 7'h21};
                8'h1E: {lo, hi} = {7'h32, 7'h40};
                8'h26: {lo, hi} = {7'h33, 7'h23};
                8'h25: {lo, hi} = {7'h34, 7'h24};
                8'h2E: {lo, hi} = {7'h35, 7'h25};
                8'h36: {lo, hi} = {7'h36, 7'h5E};
                8'h3D: {lo, hi} = {7'h37, 7'h26};
                8'h3E: {lo, hi} = {7'h38, 7'h2A};
                8'h46: {lo, hi} = {7'h39, 7'h28};
                8'h4E: {lo, hi} = {7'h2D, 7'h5F};
                8'h55: {lo, hi} = {7'h3D, 7'h2B};
                8'h41: {lo, hi} = {7'h2C, 7'h3C};
                8'h49: {lo, hi} = {7'h2E, 7'h3E};
                8'h4A: {lo, hi} = {7'h2F, 7'h3F};
                8'h29: {lo, hi} = {7'h20, 7'h20};
                8'h5A: {lo, hi} = {7'h0D, 7'h0D};
                8'h66: {lo, hi} = {7'h08, 7'h08};
                8'h0D: {lo, hi} = {7'h09, 7'h09};
                8'h76: {lo, hi} = {7'h1B, 7'h1B};
                default: {lo, hi} = {7'h01, 7'h01};
            endcase
        end
        alpha = !ext && (lo >= 7'h61) && (lo <= 7'h7A);
        if (alpha)
            return (sh ^ cp) ? (lo - 7'h20) : lo;
        return sh ? hi : lo;
    endfunction

    // Classify the incoming byte against the parser state
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        done  = 1'b0;
        d_brk = 1'b0;
        d_ext = 1'b0;
        if (byte_valid) begin
            unique case (st_q)
                S_IDLE: begin
                    if (byte_data == 8'hE0) begin
                        st_d = S_EXT;
                    end else if (byte_data == 8'hF0) begin
                        st_d = S_BRK;
                    end else if (byte_data == 8'hE1) begin
                        st_d  = S_SKIP;
                        cnt_d = 3'd7;
                    end else if (byte_data == 8'hAA || byte_data == 8'hFA ||
                                 byte_data == 8'hEE || byte_data == 8'hFC ||
                                 byte_data == 8'hFE || byte_data == 8'h00 ||
                                 byte_data == 8'hFF) begin
                        st_d = S_IDLE;
                    end else begin
                        done = 1'b1;
                    end
                end
                S_EXT: begin
                    if (byte_data == 8'hF0) begin
                        st_d = S_EXTBRK;
                    end else begin
                        st_d = S_IDLE;
                        if (byte_data != 8'h12 && byte_data != 8'h59) begin
                            done  = 1'b1;
                            d_ext = 1'b1;
                        end
                    end
                end
                S_BRK: begin
                    st_d  = S_IDLE;
                    done  = 1'b1;
                    d_brk = 1'b1;
                end
                S_EXTBRK: begin
                    st_d  = S_IDLE;
                    done  = 1'b1;
                    d_brk = 1'b1;
                    d_ext = 1'b1;
                end
                S_SKIP: begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1)
                        st_d = S_IDLE;
                end
                default: st_d = S_IDLE;
            endcase
        end
    end

    logic       k_lsh, k_rsh, k_lct, k_rct, k_caps, k_mod;
    logic [8:0] key9;
    logic       rep, push_ev, shift, ctrl;

    assign key9    = {d_ext, byte_data};
    assign k_lsh   = !d_ext && byte_data == 8'h12;
    assign k_rsh   = !d_ext && byte_data == 8'h59;
    assign k_lct   = !d_ext && byte_data == 8'h14;
    assign k_rct   =  d_ext && byte_data == 8'h14;
    assign k_caps  = !d_ext && byte_data == 8'h58;
    assign k_mod   = k_lsh | k_rsh | k_lct | k_rct | k_caps;
    assign rep     = (SUPPRESS_REPEAT != 0) && key9 == last_q;
    assign push_ev = done && !k_mod &&
                     (d_brk ? (EMIT_BREAKS != 0) : !rep);
    assign shift   = lsh_q | rsh_q;
    assign ctrl    = lct_q | rct_q;

    // Parser state register
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            st_q  <= S_IDLE;
            cnt_q <= 3'd0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    // Modifier, caps-lock and last-make tracking
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            lsh_q  <= 1'b0;
            rsh_q  <= 1'b0;
            lct_q  <= 1'b0;
            rct_q  <= 1'b0;
            caps_q <= 1'b0;
            held_q <= 1'b0;
            last_q <= 9'd0;
        end else if (done) begin
            if (k_lsh) lsh_q <= !d_brk;
            if (k_rsh) rsh_q <= !d_brk;
            if (k_lct) lct_q <= !d_brk;
            if (k_rct) rct_q <= !d_brk;
            if (k_caps) begin
                if (d_brk) begin
                    held_q <= 1'b0;
                end else begin
                    if (!held_q) caps_q <= !caps_q;
                    held_q <= 1'b1;
                end
            end
            if (!k_mod) begin
                if (!d_brk)
                    last_q <= key9;
                else if (key9 == last_q)
                    last_q <= 9'd0;
            end
        end
    end

    // Event staging register, one cycle ahead of the FIFO write
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            ev_vld_q   <= 1'b0;
            ev_code_q  <= 8'd0;
            ev_ascii_q <= 7'd0;
            ev_flags_q <= 5'd0;
        end else begin
            ev_vld_q <= push_ev;
            if (push_ev) begin
                ev_code_q  <= byte_data;
                ev_ascii_q <= to_ascii(d_ext, byte_data, shift, caps_q);
                ev_flags_q <= {d_brk, d_ext, ctrl, shift, caps_q};
            end
        end
    end

    logic pop, full, wr_en, drop;

    assign pop   = evt_valid && evt_ready;
    assign full  = cnt_fifo_q == FULL_CNT;
    assign wr_en = ev_vld_q && (!full || pop);
    assign drop  = ev_vld_q && full && !pop;

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_fifo_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (pop)   rd_q <= rd_q + 1'b1;
            case ({wr_en, pop})
                2'b10:   cnt_fifo_q <= cnt_fifo_q + 1'b1;
                2'b01:   cnt_fifo_q <= cnt_fifo_q - 1'b1;
                default: cnt_fifo_q <= cnt_fifo_q;
            endcase
            if (drop)
                ovf_q <= 1'b1;
            else if (clr_overflow)
                ovf_q <= 1'b0;
        end
    end

    // FIFO storage
    always_ff @(posedge CLOCK_50) begin
        if (wr_en)
            mem_q[wr_q] <= {ev_code_q, ev_ascii_q, ev_flags_q};
    end

    logic [19:0] head;

    assign head      = mem_q[rd_q];
    assign evt_valid = cnt_fifo_q != '0;
    assign evt_code  = evt_valid ? head[19:12] : 8'd0;
    assign evt_ascii = evt_valid ? head[11:5]  : 7'd0;
    assign evt_flags = evt_valid ? head[4:0]   : 5'd0;
    assign evt_count = cnt_fifo_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_event_queue.sv
// Bench for ps2_event_queue: default instance driven from a vector
// table, plus a DEPTH=4 / EMIT_BREAKS=1 instance for FIFO corners.
module tb_ps2_event_queue;

    logic CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    logic reset;

    logic       a_bv, a_rdy, a_clr;
    logic [7:0] a_bd;
    logic       a_v, a_ovf;
    logic [7:0] a_code;
    logic [6:0] a_asc;
    logic [4:0] a_fl;
    logic [3:0] a_cnt;

    logic       b_bv, b_rdy, b_clr;
    logic [7:0] b_bd;
    logic       b_v, b_ovf;
    logic [7:0] b_code;
    logic [6:0] b_asc;
    logic [4:0] b_fl;
    logic [2:0] b_cnt;

    ps2_event_queue u_a (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .byte_valid(a_bv), .byte_data(a_bd),
        .evt_ready(a_rdy), .clr_overflow(a_clr),
        .evt_valid(a_v), .evt_code(a_code),
        .evt_ascii(a_asc), .evt_flags(a_fl),
        .evt_count(a_cnt), .overflow(a_ovf)
    );

    ps2_event_queue #(
        .DEPTH(4), .EMIT_BREAKS(1), .SUPPRESS_REPEAT(0)
    ) u_b (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .byte_valid(b_bv), .byte_data(b_bd),
        .evt_ready(b_rdy), .clr_overflow(b_clr),
        .evt_valid(b_v), .evt_code(b_code),
        .evt_ascii(b_asc), .evt_flags(b_fl),
        .evt_count(b_cnt), .overflow(b_ovf)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int              n;
        logic [8:0][7:0] b;
        bit              ev;
        logic [7:0]      code;
        logic [6:0]      asc;
        logic [4:0]      fl;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input int n, input logic [71:0] b,
                                input bit ev, input logic [7:0] code,
                                input logic [6:0] asc, input logic [4:0] fl);
        vec_t r;
        r.n = n; r.b = b; r.ev = ev;
        r.code = code; r.asc = asc; r.fl = fl;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic send_a(input logic [7:0] b);
        a_bv = 1'b1; a_bd = b;
        tick();
        a_bv = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        b_bv = 1'b1; b_bd = b;
        tick();
        b_bv = 1'b0;
    endtask

    task automatic pop_a();
        a_rdy = 1'b1; tick(); a_rdy = 1'b0;
    endtask

    task automatic pop_b();
        b_rdy = 1'b1; tick(); b_rdy = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp4 [4];
        vec_t v;

        vecs[0]  = mk(2, {8'hF0, 8'h1C, 56'h0}, 0, 8'h00, 7'h00, 5'h00);
        vecs[1]  = mk(5, {8'hF0, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 32'h0},
                      1, 8'h1C, 7'h61, 5'h00);
        vecs[2]  = mk(4, {8'h12, 8'h32, 8'hF0, 8'h12, 40'h0},
                      1, 8'h32, 7'h42, 5'h02);
        vecs[3]  = mk(2, {8'hE0, 8'h75, 56'h0}, 1, 8'h75, 7'h02, 5'h08);
        vecs[4]  = mk(2, {8'hE0, 8'h6B, 56'h0}, 1, 8'h6B, 7'h03, 5'h08);
        vecs[5]  = mk(2, {8'hE0, 8'h72, 56'h0}, 1, 8'h72, 7'h04, 5'h08);
        vecs[6]  = mk(2, {8'hE0, 8'h74, 56'h0}, 1, 8'h74, 7'h05, 5'h08);
        vecs[7]  = mk(1, {8'h1E, 64'h0}, 1, 8'h1E, 7'h32, 5'h00);
        vecs[8]  = mk(4, {8'h59, 8'h16, 8'hF0, 8'h59, 40'h0},
                      1, 8'h16, 7'h21, 5'h02);
        vecs[9]  = mk(6, {8'hE0, 8'h14, 8'h24, 8'hE0, 8'hF0, 8'h14, 24'h0},
                      1, 8'h24, 7'h65, 5'h04);
        vecs[10] = mk(3, {8'hAA, 8'hFA, 8'h00, 48'h0}, 0, 8'h00, 7'h00, 5'h00);
        vecs[11] = mk(3, {8'hE0, 8'h12, 8'h29, 48'h0}, 1, 8'h29, 7'h20, 5'h00);
        vecs[12] = mk(9, {8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14,
                          8'hF0, 8'h77, 8'h5A}, 1, 8'h5A, 7'h0D, 5'h00);
        vecs[13] = mk(1, {8'h0E, 64'h0}, 1, 8'h0E, 7'h01, 5'h00);
        vecs[14] = mk(8, {8'h58, 8'hF0, 8'h58, 8'h58, 8'h58, 8'hF0,
                          8'h58, 8'h1C, 8'h0}, 1, 8'h1C, 7'h61, 5'h00);
        vecs[15] = mk(4, {8'h58, 8'hF0, 8'h58, 8'h4D, 40'h0},
                      1, 8'h4D, 7'h50, 5'h01);
        vecs[16] = mk(4, {8'h12, 8'h15, 8'hF0, 8'h12, 40'h0},
                      1, 8'h15, 7'h71, 5'h03);
        vecs[17] = mk(4, {8'h58, 8'hF0, 8'h58, 8'h45, 40'h0},
                      1, 8'h45, 7'h30, 5'h00);
        vecs[18] = mk(2, {8'hF0, 8'h45, 56'h0}, 0, 8'h00, 7'h00, 5'h00);
        vecs[19] = mk(4, {8'h12, 8'h45, 8'hF0, 8'h12, 40'h0},
                      1, 8'h45, 7'h29, 5'h02);

        reset = 1'b0;
        a_bv = 0; a_bd = 0; a_rdy = 0; a_clr = 0;
        b_bv = 0; b_bd = 0; b_rdy = 0; b_clr = 0;
        #25;
        chk("rst_valid", a_v, 0);
        chk("rst_code", a_code, 0);
        chk("rst_ascii", a_asc, 0);
        chk("rst_flags", a_fl, 0);
        chk("rst_count", a_cnt, 0);
        chk("rst_ovf", a_ovf, 0);
        reset = 1'b1;
        tick();

        // first-event latency with consumer always ready
        a_rdy = 1'b1;
        send_a(8'h1C);
        chk("lat_n", a_v, 0);
        tick();
        chk("lat_n1_valid", a_v, 1);
        chk("lat_code", a_code, 8'h1C);
        chk("lat_ascii", a_asc, 7'h61);
        chk("lat_flags", a_fl, 5'h00);
        tick();
        chk("lat_popped", a_v, 0);
        a_rdy = 1'b0;

        for (int i = 0; i < 20; i++) begin
            v = vecs[i];
            for (int j = 0; j < v.n; j++)
                send_a(v.b[8-j]);
            tick();
            tick();
            chk($sformatf("v%0d_count", i), a_cnt, v.ev ? 1 : 0);
            if (v.ev) begin
                chk($sformatf("v%0d_code", i), a_code, v.code);
                chk($sformatf("v%0d_ascii", i), a_asc, v.asc);
                chk($sformatf("v%0d_flags", i), a_fl, v.fl);
            end
            for (int k = 0; k < 8 && a_cnt != 0; k++)
                pop_a();
        end

        // pop on empty is ignored
        a_rdy = 1'b1; tick(); tick(); a_rdy = 1'b0;
        chk("empty_pop_count", a_cnt, 0);
        chk("empty_pop_valid", a_v, 0);

        // reset after an E0 prefix discards it
        send_a(8'hE0);
        #3 reset = 1'b0;
        #1;
        chk("midrst_count", a_cnt, 0);
        chk("midrst_valid", a_v, 0);
        #2 reset = 1'b1;
        tick();
        send_a(8'h75);
        tick(); tick();
        chk("midrst_evcount", a_cnt, 1);
        chk("midrst_code", a_code, 8'h75);
        chk("midrst_flags", a_fl, 5'h00);
        pop_a();

        // reset with an event staged but not yet queued
        send_a(8'h1C);
        reset = 1'b0;
        #2 reset = 1'b1;
        tick(); tick();
        chk("pend_rst_count", a_cnt, 0);
        send_a(8'h1C);
        tick(); tick();
        chk("lastmake_rst_count", a_cnt, 1);
        pop_a();

        // break events with shift held
        send_b(8'h12); send_b(8'h1C); send_b(8'hF0);
        send_b(8'h1C); send_b(8'hF0); send_b(8'h12);
        tick(); tick();
        chk("brk_count", b_cnt, 2);
        chk("brk_make_code", b_code, 8'h1C);
        chk("brk_make_ascii", b_asc, 7'h41);
        chk("brk_make_flags", b_fl, 5'h02);
        pop_b();
        chk("brk_code", b_code, 8'h1C);
        chk("brk_ascii", b_asc, 7'h41);
        chk("brk_flags", b_fl, 5'h12);
        pop_b();
        chk("brk_drained", b_cnt, 0);

        // repeats kept when suppression is off
        send_b(8'h1C); send_b(8'h1C);
        tick(); tick();
        chk("norep_count", b_cnt, 2);
        pop_b(); pop_b();

        // overflow on a full FIFO
        send_b(8'h1C); send_b(8'h32); send_b(8'h21);
        send_b(8'h23); send_b(8'h24);
        tick(); tick();
        chk("ovf_count", b_cnt, 4);
        chk("ovf_flag", b_ovf, 1);
        chk("ovf_head", b_code, 8'h1C);
        tick();
        chk("ovf_head_stable", b_code, 8'h1C);
        send_b(8'h2B);
        b_clr = 1'b1; tick(); b_clr = 1'b0;
        chk("ovf_drop_wins", b_ovf, 1);
        chk("ovf_drop_count", b_cnt, 4);
        b_clr = 1'b1; tick(); b_clr = 1'b0;
        chk("ovf_cleared", b_ovf, 0);
        exp4[0] = 8'h1C; exp4[1] = 8'h32;
        exp4[2] = 8'h21; exp4[3] = 8'h23;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf_drain%0d", i), b_code, exp4[i]);
            pop_b();
        end
        chk("ovf_drained", b_cnt, 0);

        // push and pop on the same edge while full
        send_b(8'h1C); send_b(8'h32); send_b(8'h21); send_b(8'h23);
        tick(); tick();
        chk("pp_full", b_cnt, 4);
        send_b(8'h24);
        b_rdy = 1'b1; tick(); b_rdy = 1'b0;
        chk("pp_count", b_cnt, 4);
        chk("pp_ovf", b_ovf, 0);
        exp4[0] = 8'h32; exp4[1] = 8'h21;
        exp4[2] = 8'h23; exp4[3] = 8'h24;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pp_drain%0d", i), b_code, exp4[i]);
            pop_b();
        end
        chk("pp_drained", b_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
